// File: rtl/sigmoid_backward.sv
// sigmoid_backward
// Backward pass of a sigmoid layer: dL/dx = dL/dy * y * (1 - y).
// Forward activations y are cached in a FIFO. Each accepted gradient pops
// the oldest y. A 3-stage pipeline then forms the product, and the result
// appears 3 cycles after the gradient is accepted.
//
// Ports
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   flush              : synchronous clear of the cache and sticky flags
//   act_in/act_valid   : activation to cache (unsigned, ACT_INT integer bits)
//   grad_in/grad_valid : upstream gradient (signed, GRAD_INT integer bits)
//   dout/dout_valid    : downstream gradient, same format as grad_in
//   count, full, empty : cache occupancy and status
//   overflow/underflow : sticky flags for a dropped push or a dropped gradient
module sigmoid_backward #(
   parameter int ACT_WIDTH  = 16,
   parameter int ACT_INT    = 1,
   parameter int GRAD_WIDTH = 16,
   parameter int GRAD_INT   = 4,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [ACT_WIDTH-1:0]    act_in,
   input  logic                    act_valid,
   input  logic [GRAD_WIDTH-1:0]   grad_in,
   input  logic                    grad_valid,
   output logic [GRAD_WIDTH-1:0]   dout,
   output logic                    dout_valid,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int F_A = ACT_WIDTH - ACT_INT;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int YDW = ACT_WIDTH + F_A + 1;     // y * (1-y) product width
   localparam int GPW = GRAD_WIDTH + ACT_WIDTH + 1; // grad * p product width
   localparam logic [ACT_WIDTH-1:0] ONE_A = {{(ACT_WIDTH-1){1'b0}}, 1'b1} << F_A;

   // The gradient format is passed through unchanged, so GRAD_INT only needs
   // to describe a legal format.
   if (GRAD_INT < 1 || GRAD_INT > GRAD_WIDTH || ACT_INT < 1 || DEPTH < 2 ||
       (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("sigmoid_backward: illegal parameter combination");
   end

   logic [ACT_WIDTH-1:0]  mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  push_s, pop_s, pop_req_s;
   logic [ACT_WIDTH-1:0]  wr_data_s, rd_data_s;

   logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [ACT_WIDTH-1:0]  s1_y_q, s1_y_d, s2_p_q, s2_p_d;
   logic [F_A:0]          s1_d_q, s1_d_d;
   logic [GRAD_WIDTH-1:0] s1_grad_q, s1_grad_d, s2_grad_q, s2_grad_d;
   logic [GRAD_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic [ACT_WIDTH-1:0]  one_minus_y_s;
   logic [YDW-1:0]        yd_prod_s;
   logic signed [GPW-1:0] g_ext_s, p_ext_s, gp_prod_s, gp_shift_s;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == {CW{1'b0}});
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign dout      = dout_q;
   assign dout_valid = dout_valid_q;

   // FIFO control: push/pop qualification, pointers, occupancy and sticky flags.
   always_comb begin
      wr_data_s = (act_in >= ONE_A) ? ONE_A : act_in;
      rd_data_s = mem_q[rd_ptr_q];
      pop_req_s = grad_valid & ~empty;
      // A pop in the same cycle frees a slot, so a full cache still accepts.
      pop_s     = pop_req_s & ~flush;
      push_s    = act_valid & (~full | pop_req_s) & ~flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = {AW{1'b0}};
         rd_ptr_d    = {AW{1'b0}};
         count_d     = {CW{1'b0}};
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
         overflow_d  = overflow_q | (act_valid & full & ~pop_req_s);
         underflow_d = underflow_q | (grad_valid & empty);
      end
   end

   // Datapath: S1 captures y, grad and (1-y); S2 forms p = y(1-y); S3 scales grad.
   always_comb begin
      one_minus_y_s = ONE_A - rd_data_s;
      s1_valid_d = pop_s;
      if (pop_s) begin
         s1_y_d    = rd_data_s;
         s1_d_d    = one_minus_y_s[F_A:0];
         s1_grad_d = grad_in;
      end else begin
         s1_y_d    = s1_y_q;
         s1_d_d    = s1_d_q;
         s1_grad_d = s1_grad_q;
      end

      yd_prod_s  = {{(F_A+1){1'b0}}, s1_y_q} * {{ACT_WIDTH{1'b0}}, s1_d_q};
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
         s2_p_d    = yd_prod_s[F_A +: ACT_WIDTH];
         s2_grad_d = s1_grad_q;
      end else begin
         s2_p_d    = s2_p_q;
         s2_grad_d = s2_grad_q;
      end

      // p <= 0.25, so the scaled result always fits GRAD_WIDTH; no saturation.
      g_ext_s    = {{(ACT_WIDTH+1){s2_grad_q[GRAD_WIDTH-1]}}, s2_grad_q};
      p_ext_s    = {{(GRAD_WIDTH+1){1'b0}}, s2_p_q};
      gp_prod_s  = g_ext_s * p_ext_s;
      gp_shift_s = gp_prod_s >>> F_A;
      dout_valid_d = s2_valid_q;
      if (s2_valid_q) begin
         dout_d = gp_shift_s[GRAD_WIDTH-1:0];
      end else begin
         dout_d = dout_q;
      end
   end

   // Activation storage; data needs no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_data_s;
      end
   end

   // Control and pipeline state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {CW{1'b0}};
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_y_q       <= {ACT_WIDTH{1'b0}};
         s1_d_q       <= {(F_A+1){1'b0}};
         s1_grad_q    <= {GRAD_WIDTH{1'b0}};
         s2_valid_q   <= 1'b0;
         s2_p_q       <= {ACT_WIDTH{1'b0}};
         s2_grad_q    <= {GRAD_WIDTH{1'b0}};
         dout_q       <= {GRAD_WIDTH{1'b0}};
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         s1_valid_q   <= s1_valid_d;
         s1_y_q       <= s1_y_d;
         s1_d_q       <= s1_d_d;
         s1_grad_q    <= s1_grad_d;
         s2_valid_q   <= s2_valid_d;
         s2_p_q       <= s2_p_d;
         s2_grad_q    <= s2_grad_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

endmodule

// File: tb/tb_sigmoid_backward.sv
// Self-checking bench for sigmoid_backward (ACT 16/1, GRAD 16/4, DEPTH 16).
// The reference model keeps a queue of cached activations and a queue of
// pending results tagged with the cycle at which each must appear.
module tb_sigmoid_backward;
   localparam int DEPTH = 16;

   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
   logic        act_valid = 1'b0, grad_valid = 1'b0;
   logic [15:0] act_in = 16'h0, grad_in = 16'h0;
   logic [15:0] dout;
   logic        dout_valid, full, empty, overflow, underflow;
   logic [4:0]  count;

   sigmoid_backward #(.ACT_WIDTH(16), .ACT_INT(1), .GRAD_WIDTH(16), .GRAD_INT(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .act_in(act_in), .act_valid(act_valid),
      .grad_in(grad_in), .grad_valid(grad_valid),
      .dout(dout), .dout_valid(dout_valid), .count(count),
      .full(full), .empty(empty), .overflow(overflow), .underflow(underflow));

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0;

   typedef struct { int due; logic [15:0] val; } pend_t;
   logic [15:0] m_fifo[$];
   pend_t       pend[$];
   bit          m_ovf = 1'b0, m_udf = 1'b0, exp_valid = 1'b0;
   logic [15:0] exp_dout = 16'h0;

   function automatic logic [15:0] clamp(input logic [15:0] a);
      return (a >= 16'h8000) ? 16'h8000 : a;
   endfunction

   // dL/dx = g * y * (1-y) with y in Q1.15, g in Q4.12; p truncated, result floored.
   function automatic logic [15:0] ref_dout(input logic [15:0] g, input logic [15:0] y);
      longint yy, p, gg, prod, q;
      logic [63:0] qb;
      yy   = longint'(y);
      p    = (yy * (64'sd32768 - yy)) / 64'sd32768;
      gg   = longint'($signed(g));
      prod = gg * p;
      q    = prod / 64'sd32768;
      if (prod < 0 && (prod % 64'sd32768) != 0) q = q - 1;
      qb = q;
      return qb[15:0];
   endfunction

   // Apply one cycle of stimulus, advance the model across the edge, sample at +1.
   task automatic cycle(input bit av, input logic [15:0] a, input bit gv, input logic [15:0] g, input bit fl);
      bit do_pop, do_push;
      logic [15:0] y;
      pend_t e;
      act_valid = av; act_in = a; grad_valid = gv; grad_in = g; flush = fl;
      do_pop  = gv && (m_fifo.size() != 0) && !fl;
      do_push = av && ((m_fifo.size() < DEPTH) || do_pop) && !fl;
      @(posedge clk);
      cyc++;
      if (fl) begin
         m_fifo.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (av && !do_push) m_ovf = 1'b1;
         if (gv && !do_pop) m_udf = 1'b1;
         if (do_pop) begin
            y = m_fifo.pop_front();
            e.due = cyc + 2; e.val = ref_dout(g, y);
            pend.push_back(e);
         end
         if (do_push) m_fifo.push_back(clamp(a));
      end
      #1;
      act_valid = 1'b0; grad_valid = 1'b0; flush = 1'b0;
      exp_valid = 1'b0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
         exp_valid = 1'b1; exp_dout = pend[0].val;
         void'(pend.pop_front());
      end
   endtask

   task automatic idle();
      cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic model_reset();
      m_fifo.delete(); pend.delete();
      m_ovf = 1'b0; m_udf = 1'b0; exp_valid = 1'b0; exp_dout = 16'h0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 17; i++) cycle(1'b1, 16'h2000, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 16'h1000, 1'b0);
      idle();
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_status: got empty=%b full=%b expected 1/0", empty, full); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0/0", overflow, underflow); end
      checks++; if (dout !== 16'h0 || dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout: got %h/%b expected 0000/0", dout, dout_valid); end
      @(posedge clk); cyc++; #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_no_result: got dout_valid=%b expected 0", dout_valid); end
      end
   endtask

   task automatic test_basic();
      cycle(1'b1, 16'h4000, 1'b0, 16'h0, 1'b0);
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", count); end
      cycle(1'b0, 16'h0, 1'b1, 16'h1000, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b expected 1", empty); end
      idle();
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got dout_valid=%b expected 0", dout_valid); end
      idle();
      checks++; if (dout_valid !== 1'b1 || dout !== 16'h0400) begin errors++; $display("FAIL basic_dout: got %h valid=%b expected 0400 valid=1", dout, dout_valid); end
      idle();
      checks++; if (dout_valid !== 1'b0 || dout !== 16'h0400) begin errors++; $display("FAIL basic_hold: got %h valid=%b expected 0400 valid=0", dout, dout_valid); end
   endtask

   task automatic test_neg_clamp();
      logic [15:0] acts [4] = '{16'h4000, 16'h9000, 16'h0000, 16'hFFFF};
      logic [15:0] grads[4] = '{16'hF000, 16'h1000, 16'h1000, 16'h7FFF};
      logic [15:0] want [4] = '{16'hFC00, 16'h0000, 16'h0000, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, acts[i], 1'b0, 16'h0, 1'b0);
         cycle(1'b0, 16'h0, 1'b1, grads[i], 1'b0);
         idle(); idle();
         checks++;
         if (dout_valid !== 1'b1 || dout !== want[i]) begin
            errors++; $display("FAIL neg_clamp[%0d]: got %h valid=%b expected %h valid=1", i, dout, dout_valid, want[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int results = 0;
      for (int i = 0; i < 17; i++) cycle(1'b1, 16'($urandom_range(0, 32767)), 1'b0, 16'h0, 1'b0);
      checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_state: got count=%0d full=%b ovf=%b expected 16/1/1", count, full, overflow); end
      for (int i = 0; i < 18; i++) begin
         if (i < 16) cycle(1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0);
         else idle();
         checks++;
         if (dout_valid !== exp_valid || dout !== exp_dout) begin
            errors++; $display("FAIL ovf_drain[%0d]: got %h valid=%b expected %h valid=%b", i, dout, dout_valid, exp_dout, exp_valid);
         end
         if (dout_valid === 1'b1) results++;
      end
      checks++; if (empty !== 1'b1 || results != 16) begin errors++; $display("FAIL ovf_final: got empty=%b results=%0d expected 1/16", empty, results); end
   endtask

   task automatic test_underflow_flush();
      cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", overflow); end
      cycle(1'b0, 16'h0, 1'b1, 16'h1000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL udf_no_result: got dout_valid=%b expected 0", dout_valid); end
      end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b expected 1", underflow); end
      cycle(1'b1, 16'h4000, 1'b0, 16'h0, 1'b1);
      checks++; if (underflow !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL flush_clear: got udf=%b count=%0d expected 0/0", underflow, count); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 16; i++) cycle(1'b1, 16'($urandom_range(0, 40000)), 1'b0, 16'h0, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_full: got %b expected 1", full); end
      cycle(1'b1, 16'h1234, 1'b1, 16'($urandom), 1'b0);
      checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL simul_both: got count=%0d ovf=%b expected 16/0", count, overflow); end
      for (int i = 0; i < 18; i++) begin
         if (i < 16) cycle(1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0);
         else idle();
         checks++;
         if (dout_valid !== exp_valid || dout !== exp_dout) begin
            errors++; $display("FAIL simul_drain[%0d]: got %h valid=%b expected %h valid=%b", i, dout, dout_valid, exp_dout, exp_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 16'h4000, 1'b0, 16'h0, 1'b0);
      cycle(1'b1, 16'h2000, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 16'h1000, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 16'h1000, 1'b0);
      #2 rst = 1'b1;
      @(posedge clk); cyc++; #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         idle();
         checks++; if (dout_valid !== 1'b0 || dout !== 16'h0) begin errors++; $display("FAIL rst_mid[%0d]: got %h valid=%b expected 0000 valid=0", i, dout, dout_valid); end
      end
   endtask

   task automatic test_random();
      bit av, gv, fl;
      logic [15:0] a;
      int pp, gp;
      for (int i = 0; i < 3000; i++) begin
         pp = ((i / 300) % 2 == 0) ? 75 : 35;
         gp = 100 - pp;
         av = ($urandom_range(0, 99) < pp);
         gv = ($urandom_range(0, 99) < gp);
         fl = ($urandom_range(0, 249) == 0);
         a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32768, 65535)) : 16'($urandom_range(0, 32767));
         cycle(av, a, gv, 16'($urandom), fl);
         checks++;
         if (dout_valid !== exp_valid || dout !== exp_dout) begin
            errors++; $display("FAIL rand_dout[%0d]: got %h valid=%b expected %h valid=%b", i, dout, dout_valid, exp_dout, exp_valid);
         end
         checks++;
         if (count !== 5'(m_fifo.size()) || full !== (m_fifo.size() == DEPTH) || empty !== (m_fifo.size() == 0)) begin
            errors++; $display("FAIL rand_count[%0d]: got count=%0d full=%b empty=%b expected count=%0d", i, count, full, empty, m_fifo.size());
         end
         checks++;
         if (overflow !== m_ovf || underflow !== m_udf) begin
            errors++; $display("FAIL rand_flags[%0d]: got ovf=%b udf=%b expected %b/%b", i, overflow, underflow, m_ovf, m_udf);
         end
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      @(posedge clk); cyc++; #1 rst = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_neg_clamp();
      test_overflow();
      test_underflow_flush();
      test_full_simul();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sigmoid_backward.md
SIGMOID_BACKWARD -- requirements
Module: sigmoid_backward

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 16, activation width (unsigned, forward sigmoid output format).
REQ-002 SHALL have parameter ACT_INT, default 1, activation integer bits; F_A = ACT_WIDTH-ACT_INT fractional bits.
REQ-003 SHALL have parameter GRAD_WIDTH, default 16, gradient width (signed, two's complement), for input and output.
REQ-004 SHALL have parameter GRAD_INT, default 4, gradient integer bits, sign included.
REQ-005 SHALL have parameter DEPTH, default 16, activation cache depth, power of 2, >=2.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port flush  input  1  synchronous clear of the cache and sticky flags.
REQ-009 SHALL have port act_in  input  ACT_WIDTH  forward sigmoid output to cache.
REQ-010 SHALL have port act_valid  input  1  act_in qualifier.
REQ-011 SHALL have port grad_in  input  GRAD_WIDTH  upstream gradient dL/dy.
REQ-012 SHALL have port grad_valid  input  1  grad_in qualifier.
REQ-013 SHALL have port dout  output  GRAD_WIDTH  dL/dx = grad*y*(1-y).
REQ-014 SHALL have port dout_valid  output  1  dout qualifier, one-cycle pulse per result.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  cached activations.
REQ-016 SHALL have ports full, empty  output  1 each  cache status (combinational from count).
REQ-017 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL cache activations in a DEPTH-entry FIFO; push when act_valid=1 and not full.
REQ-019 SHALL clamp on push: act_in >= 2^F_A (1.0) is stored as exactly 2^F_A.
REQ-020 SHALL pop one activation per grad_valid=1 cycle when not empty; the popped y pairs with that grad_in, in FIFO order.
REQ-021 SHALL drop act_in when full with no same-cycle pop, and set overflow; count unchanged.
REQ-022 SHALL drop grad_in when empty, produce no dout_valid, and set underflow; no same-cycle bypass of act_in to grad_in.
REQ-023 SHALL allow simultaneous push and pop when full; both succeed, count unchanged, overflow not set.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL pipeline 3 stages: S1 register y, grad, d=2^F_A-y (F_A+1 bits); S2 p=(y*d)>>F_A, truncated, unsigned ACT_WIDTH, range [0, 2^(F_A-2)]; S3 dout=(grad*p)>>>F_A, arithmetic shift (floor), GRAD_WIDTH.
REQ-026 SHALL assert dout_valid exactly 3 cycles after the accepting grad_valid cycle; back-to-back grads give back-to-back results at full throughput.
REQ-027 SHALL not saturate, since |p|<=0.25 guarantees fit; dout holds its last value while dout_valid=0.
REQ-028 SHALL, on flush, empty the FIFO and clear overflow/underflow next cycle; push/pop that cycle are ignored; in-flight pipeline results still emerge.
REQ-029 SHALL give flush priority over push/pop when both occur.

Reset
REQ-030 SHALL, on rst=1, immediately clear count=0, empty=1, full=0, overflow=0, underflow=0, dout=0, dout_valid=0 and all pipeline valids; a mid-pipeline reset discards in-flight results.
REQ-031 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification (ACT 16/1, GRAD 16/4, DEPTH 16)
REQ-032 SHALL check: push 0x4000 (0.5), then grad 0x1000 (1.0) -> dout=0x0400, dout_valid 3 cycles later, empty=1.
REQ-033 SHALL check: push 0x4000, grad 0xF000 (-1.0) -> dout=0xFC00; push 0x0000 or 0x9000 (clamped), grad 0x1000 -> dout=0x0000.
REQ-034 SHALL check: 17 pushes -> count=16, full=1, overflow=1; 16 grads return results in push order; then empty=1.
REQ-035 SHALL check: grad_valid while empty -> no dout_valid, underflow=1; flush -> underflow=0, count=0.
REQ-036 SHALL check: full plus simultaneous push and grad -> count stays 16, overflow=0; rst mid-pipeline -> no dout_valid afterward.
REQ-037 SHALL check: random stream of interleaved push/grad against a reference model -> bit-exact dout and ordering.
